// File: rtl/bcd_to_b16.sv
// Five-digit BCD to 16-bit binary converter.
// One multiply-by-10-and-add step per clock, start/busy/done handshake.
module bcd_to_b16 #(
  parameter logic [3:0] NULL_VALUE    = 4'b1111,
  parameter bit         BLANK_AS_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  D5,
  input  logic [3:0]  D4,
  input  logic [3:0]  D3,
  input  logic [3:0]  D2,
  input  logic [3:0]  D1,
  output logic        busy,
  output logic        done,
  output logic [15:0] value,
  output logic        invalid_digit,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [19:0] digs;
  logic [2:0]  idx;
  logic [16:0] acc;
  logic        err;

  logic [3:0]  cur;
  logic        is_null;
  logic        bad;
  logic [3:0]  d_eff;
  logic [16:0] acc_nx;
  logic        err_nx;
  logic        accept;
  logic        last;

  // Digits are shifted out MSB-first, so the current digit is the top nibble.
  assign cur     = digs[19:16];
  assign is_null = (cur == NULL_VALUE);
  assign bad     = is_null ? !BLANK_AS_ZERO : (cur > 4'd9);
  assign d_eff   = (is_null || bad) ? 4'd0 : cur;
  assign acc_nx  = (acc << 3) + (acc << 1) + 17'(d_eff);
  assign err_nx  = err | bad;
  assign last    = (state == CONV) && (idx == 3'd4);
  assign accept  = start && ((state == IDLE) || (state == DONE));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (idx == 3'd4) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? CONV : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Digit latch, accumulator and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digs <= '0;
      idx  <= '0;
      acc  <= '0;
      err  <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          digs <= {D5, D4, D3, D2, D1};
          idx  <= '0;
          acc  <= '0;
          err  <= 1'b0;
        end
        (state == CONV): begin
          digs <= {digs[15:0], 4'd0};
          idx  <= idx + 3'd1;
          acc  <= acc_nx;
          err  <= err_nx;
        end
        default: ;
      endcase
    end
  end

  // Result registers update only on the final step and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value         <= '0;
      invalid_digit <= 1'b0;
      overflow      <= 1'b0;
    end else if (last) begin
      if (err_nx) begin
        value         <= '0;
        invalid_digit <= 1'b1;
        overflow      <= 1'b0;
      end else begin
        value         <= acc_nx[15:0];
        invalid_digit <= 1'b0;
        overflow      <= acc_nx[16];
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_b16.sv
// Randomised self-checking bench for bcd_to_b16.
// Two instances share stimulus: blanks-as-zero and blanks-illegal.
module tb_bcd_to_b16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [19:0] dg = '0;

  logic        busy1, done1, inv1, ovf1;
  logic [15:0] val1;
  logic        busy0, done0, inv0, ovf0;
  logic [15:0] val0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_to_b16 #(.BLANK_AS_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .D5(dg[19:16]), .D4(dg[15:12]), .D3(dg[11:8]),
    .D2(dg[7:4]), .D1(dg[3:0]),
    .busy(busy1), .done(done1), .value(val1),
    .invalid_digit(inv1), .overflow(ovf1)
  );

  bcd_to_b16 #(.BLANK_AS_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .D5(dg[19:16]), .D4(dg[15:12]), .D3(dg[11:8]),
    .D2(dg[7:4]), .D1(dg[3:0]),
    .busy(busy0), .done(done0), .value(val0),
    .invalid_digit(inv0), .overflow(ovf0)
  );

  // Reference: positional decimal weights, then the status rules.
  function automatic void model(
    input  logic [19:0] d,
    input  bit          baz,
    output logic [15:0] v,
    output logic        inv,
    output logic        ovf
  );
    int total;
    int w;
    bit bd;
    logic [3:0] n;
    total = 0;
    w = 10000;
    bd = 0;
    for (int i = 0; i < 5; i++) begin
      n = d[19-4*i -: 4];
      if (n <= 4'd9) total += int'(n) * w;
      else if (!(n == 4'hF && baz)) bd = 1;
      w = w / 10;
    end
    if (bd) begin
      v = '0;
      inv = 1'b1;
      ovf = 1'b0;
    end else begin
      v = total[15:0];
      inv = 1'b0;
      ovf = (total > 65535);
    end
  endfunction

  function automatic logic [19:0] rand_digits();
    logic [19:0] r;
    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(0, 4) == 0)
        r[4*i +: 4] = 4'($urandom_range(10, 15));
      else
        r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // Launch one conversion, scramble inputs during CONV, wait for done.
  task automatic do_conv(
    input  logic [19:0] d,
    output int          cyc,
    output int          bcnt
  );
    @(posedge clk);
    #1;
    dg = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dg = 20'($urandom);
    cyc = 0;
    bcnt = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy1) bcnt++;
      if (done1) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy1, done1, val1, inv1, ovf1} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_async got %h want 0",
               {busy1, done1, val1, inv1, ovf1});
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if ({busy1, done1} !== 2'b00) begin
        n_err++;
        $display("FAIL idle_busy_done cyc %0d got %b want 00",
                 i, {busy1, done1});
      end
    end
  endtask

  task automatic test_nominal();
    int cyc, bcnt;
    do_conv(20'h12345, cyc, bcnt);
    n_vec++;
    if (cyc !== 6) begin
      n_err++;
      $display("FAIL nom_latency got %0d want 6", cyc);
    end
    n_vec++;
    if (bcnt !== 5) begin
      n_err++;
      $display("FAIL nom_busy_cycles got %0d want 5", bcnt);
    end
    n_vec++;
    if ({val1, inv1, ovf1} !== {16'd12345, 2'b00}) begin
      n_err++;
      $display("FAIL nom_value got %0d/%b%b want 12345/00",
               val1, inv1, ovf1);
    end
    @(negedge clk);
    n_vec++;
    if ({done1, val1} !== {1'b0, 16'd12345}) begin
      n_err++;
      $display("FAIL nom_hold got done=%b v=%0d want 0/12345",
               done1, val1);
    end
  endtask

  task automatic test_boundaries();
    logic [19:0] tbl [3];
    logic [15:0] ev [3];
    logic        eo [3];
    int cyc, bcnt;
    tbl[0] = 20'h65535; ev[0] = 16'd65535; eo[0] = 1'b0;
    tbl[1] = 20'h65536; ev[1] = 16'd0;     eo[1] = 1'b1;
    tbl[2] = 20'h99999; ev[2] = 16'd34463; eo[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_conv(tbl[i], cyc, bcnt);
      n_vec++;
      if ({done1, val1, inv1, ovf1} !== {1'b1, ev[i], 1'b0, eo[i]}) begin
        n_err++;
        $display("FAIL bound_%h got d=%b v=%0d i=%b o=%b want v=%0d o=%b",
                 tbl[i], done1, val1, inv1, ovf1, ev[i], eo[i]);
      end
    end
  endtask

  task automatic test_blanks();
    int cyc, bcnt;
    do_conv(20'hFFF42, cyc, bcnt);
    n_vec++;
    if ({val1, inv1, ovf1} !== {16'd42, 2'b00}) begin
      n_err++;
      $display("FAIL blank_zero got %0d/%b%b want 42/00",
               val1, inv1, ovf1);
    end
    n_vec++;
    if ({done0, val0, inv0, ovf0} !== {1'b1, 16'd0, 2'b10}) begin
      n_err++;
      $display("FAIL blank_illegal got d=%b %0d/%b%b want 1 0/10",
               done0, val0, inv0, ovf0);
    end
    do_conv(20'h00A00, cyc, bcnt);
    n_vec++;
    if ({val1, inv1, ovf1} !== {16'd0, 2'b10}) begin
      n_err++;
      $display("FAIL digit_A got %0d/%b%b want 0/10",
               val1, inv1, ovf1);
    end
  endtask

  task automatic test_start_in_conv();
    int nd;
    logic [15:0] v;
    @(posedge clk);
    #1;
    dg = 20'h00777;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dg = 20'h99999;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    v = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done1) begin
        nd++;
        v = val1;
      end
    end
    n_vec++;
    if (nd !== 1) begin
      n_err++;
      $display("FAIL start_in_conv dones got %0d want 1", nd);
    end
    n_vec++;
    if (v !== 16'd777) begin
      n_err++;
      $display("FAIL start_in_conv value got %0d want 777", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] a, b;
    logic [15:0] ea, eb, e;
    logic ei, eo;
    int idxq [$];
    logic [15:0] valq [$];
    a = rand_digits();
    b = rand_digits();
    model(a, 1'b1, ea, ei, eo);
    model(b, 1'b1, eb, ei, eo);
    @(posedge clk);
    #1;
    dg = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    dg = b;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (done1) begin
        idxq.push_back(k);
        valq.push_back(val1);
      end
    end
    start = 1'b0;
    n_vec++;
    if (idxq.size() !== 3) begin
      n_err++;
      $display("FAIL b2b_count got %0d want 3", idxq.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        e = (j == 0) ? ea : eb;
        n_vec++;
        if (idxq[j] !== 6 * (j + 1) || valq[j] !== e) begin
          n_err++;
          $display("FAIL b2b_%0d got cyc=%0d v=%0d want cyc=%0d v=%0d",
                   j, idxq[j], valq[j], 6 * (j + 1), e);
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int cyc, bcnt, nd;
    do_conv(20'h54321, cyc, bcnt);
    @(posedge clk);
    #1;
    dg = 20'h11111;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy1, done1, val1, inv1, ovf1} !== 20'd0) begin
      n_err++;
      $display("FAIL abort_async got %h want 0",
               {busy1, done1, val1, inv1, ovf1});
    end
    #1;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done1 || busy1) nd++;
    end
    n_vec++;
    if (nd !== 0 || val1 !== 16'd0) begin
      n_err++;
      $display("FAIL abort_quiet got act=%0d v=%0d want 0/0", nd, val1);
    end
    do_conv(20'h00808, cyc, bcnt);
    n_vec++;
    if (cyc !== 6 || val1 !== 16'd808 || {inv1, ovf1} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_recover got cyc=%0d v=%0d want 6/808",
               cyc, val1);
    end
  endtask

  task automatic test_random();
    logic [19:0] d;
    logic [15:0] ev1, ev0;
    logic ei1, eo1, ei0, eo0;
    int cyc, bcnt;
    for (int t = 0; t < 150; t++) begin
      d = rand_digits();
      model(d, 1'b1, ev1, ei1, eo1);
      model(d, 1'b0, ev0, ei0, eo0);
      do_conv(d, cyc, bcnt);
      n_vec++;
      if (cyc !== 6) begin
        n_err++;
        $display("FAIL rnd_latency %h got %0d want 6", d, cyc);
      end
      n_vec++;
      if ({val1, inv1, ovf1} !== {ev1, ei1, eo1}) begin
        n_err++;
        $display("FAIL rnd_baz1 %h got %0d/%b%b want %0d/%b%b",
                 d, val1, inv1, ovf1, ev1, ei1, eo1);
      end
      n_vec++;
      if ({done0, val0, inv0, ovf0} !== {1'b1, ev0, ei0, eo0}) begin
        n_err++;
        $display("FAIL rnd_baz0 %h got d=%b %0d/%b%b want %0d/%b%b",
                 d, done0, val0, inv0, ovf0, ev0, ei0, eo0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_boundaries();
    test_blanks();
    test_start_in_conv();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
